sram_fifo_ctrl: RTL
===================

# sram_fifo_ctrl

Single-clock FIFO controller that turns the 8x32 flip-flop SRAM into a valid/ready FIFO. It sits directly upstream of the SRAM and drives its address, write-enable and write-data pins. It consumes the SRAM's registered read data into a one-entry output register. Upstream producers push words; the downstream consumer pops from the output register.

## Interface
- WIDTH, 32: data width; must match the SRAM word.
- DEPTH, 8: SRAM entries; power of two.
- ADDR_W, 3: log2(DEPTH).

- driver_clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  reset, asynchronous, active-high.
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts the word this cycle.
- in_data  in  WIDTH  word to push.
- out_valid  out  1  output register holds the FIFO head.
- out_ready  in  1  consumer pops the head this cycle.
- out_data  out  WIDTH  FIFO head.
- mem_add  out  ADDR_W  SRAM address.
- mem_we  out  1  SRAM write enable; 1 = write, 0 = read.
- mem_wd  out  WIDTH  SRAM write data.
- mem_rd  in  WIDTH  SRAM read data, registered by the SRAM.
- count  out  ADDR_W+1  total words held: sc + rd_pend + out_valid, range 0..DEPTH+1.
- full  out  1  sc == DEPTH.
- empty  out  1  count == 0.

## Operation
- Registers:
  - wr_ptr, rd_ptr: ADDR_W bits, wrap modulo DEPTH.
  - sc: words in SRAM not yet read, 0..DEPTH.
  - rd_pend: a read was issued last cycle.
  - out_valid, out_data.
- The SRAM is single-port, so at most one access per cycle. Arbitration uses registered state only, with no combinational path from out_ready or in_valid to in_ready.
- rd_go = (sc != 0) && !rd_pend && !out_valid. Reads have priority.
- Read cycle (rd_go = 1):
  - mem_we = 0, mem_add = rd_ptr.
  - rd_ptr increments and sc decrements at the edge.
  - rd_pend is set for the next cycle.
- in_ready = !resetn_active && (sc != DEPTH) && !rd_go.
- Write cycle (in_valid && in_ready):
  - mem_we = 1, mem_add = wr_ptr, mem_wd = in_data.
  - wr_ptr increments and sc increments at the edge.
- Idle cycle:
  - mem_we = 0, mem_add = wr_ptr, mem_wd = in_data.
  - The SRAM read result is ignored.
- rd_pend cycle: mem_rd is the word addressed in the previous cycle. At the edge, out_data <= mem_rd, out_valid <= 1, and rd_pend clears.
- Pop: when out_valid && out_ready, out_valid clears at the edge. The next read can issue in the following cycle.
- Simultaneous push and pop: both are honoured, since they never contend for the SRAM in the same cycle.
- Push to the same address read in the next cycle returns the new data, because the SRAM write completes at the edge.

## Timing
- Reset (asynchronous):
  - wr_ptr, rd_ptr, sc, rd_pend, out_valid = 0; out_data = 0.
  - Consequently count = 0, empty = 1, full = 0.
  - While resetn is high: mem_we = 0, in_ready = 0.
- Reset mid-operation discards all words. SRAM contents are not cleared, but pointers return to 0.
- Latency from an accepted write into an empty FIFO to out_valid: 3 cycles.
  - Cycle 0: write.
  - Cycle 1: read issued.
  - Cycle 2: rd_pend.
  - Cycle 3: out_valid = 1.
- Sustained read throughput: one word per 3 cycles. Writes fill all non-read cycles.
- Full: in_ready = 0 and in_data is ignored. Popping from the output register does not free SRAM space until the next read.
- Empty: out_valid = 0 and out_data holds its last value.

## Configuration
- SRAM_FIFO_STALL_CNT_EN defined:
  - Adds output stall_cnt (16 bits).
  - It counts cycles with in_valid && !in_ready, saturating at 0xFFFF.
  - Reset to 0.
- SRAM_FIFO_STALL_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- sram_fifo_pkg: WIDTH/DEPTH/ADDR_W defaults, the pointer typedef, and the count typedef.
- One sub-module, sram_fifo_ptr:
  - Holds wr_ptr, rd_ptr and sc.
  - Inputs: push and pop strobes.
  - Outputs: pointers, sc and full.
- The top level holds arbitration, rd_pend, the output register and the optional stall counter.
- The SRAM itself is instantiated beside this block at the integration level, not inside it.

## Test plan
- Reset, then push 0x11111111, 0x22222222, 0x33333333 with out_ready = 0:
  - Writes go to addresses 0, 1 and 2.
  - in_ready = 0 in cycle 1, when the read is issued.
  - out_valid = 1 with out_data = 0x11111111 three cycles after the first write.
- Push 10 words with out_ready = 0:
  - count reaches 9, full = 1, in_ready = 0.
  - The 10th word is never written.
  - Draining returns exactly the first 9 words in order.
- Continuous push of 20 incrementing words with out_ready = 1:
  - Output is identical and in order.
  - Pointers wrap from 7 to 0 without loss or duplication.
- Assert resetn with 5 words held:
  - Next cycle out_valid = 0, count = 0, empty = 1.
  - Then pushing 0xDEADBEEF returns 0xDEADBEEF as the first output.
- With SRAM_FIFO_STALL_CNT_EN defined, hold in_valid = 1 for 4 cycles while full: stall_cnt = 4. Reset returns it to 0.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_fifo_pkg
// Description : Shared defaults and types for the SRAM-backed FIFO controller.
//               It holds the width, depth and address-width defaults, the
//               SRAM pointer type and the occupancy-count type.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_fifo_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ADDR_W = 3;

    // SRAM word pointer. It wraps modulo DEPTH.
    typedef logic [DEF_ADDR_W-1:0] ptr_t;

    // The count type has one extra bit so that it can hold DEPTH+1
    // (the SRAM is full and the output register is also occupied).
    typedef logic [DEF_ADDR_W:0]   cnt_t;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage : sram_fifo_pkg
`default_nettype wire

// File: rtl/sram_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : sram_fifo_ptr
// Description : Write/read pointers and SRAM occupancy (sc) for the SRAM FIFO.
//               push_i advances wr_ptr and increments sc. pop_i (a read issued)
//               advances rd_ptr and decrements sc.
// Ports       : driver_clk  - clock
//               resetn      - asynchronous reset, active-high
//               push_i      - a word is written to the SRAM this cycle
//               pop_i       - a word is read from the SRAM this cycle
//               wr_ptr_o    - next SRAM write address
//               rd_ptr_o    - next SRAM read address
//               sc_o        - words in the SRAM that have not been read yet
//               full_o      - sc == DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sram_fifo_ptr
    import sram_fifo_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              driver_clk,
    input  logic              resetn,
    input  logic              push_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [ADDR_W-1:0] rd_ptr_o,
    output logic [ADDR_W:0]   sc_o,
    output logic              full_o
);

    localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_SC_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   sc_q,     sc_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sc_d     = sc_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        // The single-port arbiter never asserts both strobes at once. The
        // both-strobes case is still handled as "no net change" for safety.
        if (push_i && !pop_i) begin
            sc_d = sc_q + c_SC_ONE;
        end else if (pop_i && !push_i) begin
            sc_d = sc_q - c_SC_ONE;
        end
    end

    always_ff @(posedge driver_clk or posedge resetn) begin
        if (resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sc_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sc_q     <= sc_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign sc_o     = sc_q;
    assign full_o   = (sc_q == c_DEPTH);

endmodule : sram_fifo_ptr
`default_nettype wire

// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_fifo_ctrl
// Description : Single-clock valid/ready FIFO built on an external
//               single-port SRAM with a registered read. The SRAM instance
//               sits beside this block. The SRAM read data is captured into a
//               one-entry output register that the consumer pops.
// Ports       : driver_clk  - clock, rising edge
//               resetn      - asynchronous reset, active-high
//               in_valid_i / in_ready_o / in_data_i   - push side
//               out_valid_o / out_ready_i / out_data_o - pop side
//               mem_add_o / mem_we_o / mem_wd_o / mem_rd_i - SRAM pins
//               count_o     - sc + read-pending + output-valid (0..DEPTH+1)
//               full_o      - SRAM holds DEPTH unread words
//               empty_o     - count_o == 0
//               stall_cnt_o - saturating count of stalled push cycles
//                             (present only with SRAM_FIFO_STALL_CNT_EN)
// Config      : `define SRAM_FIFO_STALL_CNT_EN to add stall_cnt_o
// Revision    : 1.0 - initial release
// ============================================================================
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              driver_clk,
    input  logic              resetn,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WIDTH-1:0]  in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WIDTH-1:0]  out_data_o,
    output logic [ADDR_W-1:0] mem_add_o,
    output logic              mem_we_o,
    output logic [WIDTH-1:0]  mem_wd_o,
    input  logic [WIDTH-1:0]  mem_rd_i,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
`ifdef SRAM_FIFO_STALL_CNT_EN
    output logic [15:0]       stall_cnt_o,
`endif
    output logic              empty_o
);

    logic [ADDR_W-1:0] w_wr_ptr;
    logic [ADDR_W-1:0] w_rd_ptr;
    logic [ADDR_W:0]   w_sc;
    logic              w_full;
    logic              w_rd_go;
    logic              w_push;

    logic              rd_pend_q,   rd_pend_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;

    sram_fifo_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .driver_clk (driver_clk),
        .resetn     (resetn),
        .push_i     (w_push),
        .pop_i      (w_rd_go),
        .wr_ptr_o   (w_wr_ptr),
        .rd_ptr_o   (w_rd_ptr),
        .sc_o       (w_sc),
        .full_o     (w_full)
    );

    // Arbitration looks only at registered state, so in_ready_o never
    // depends combinationally on in_valid_i or out_ready_i. A read is issued
    // only when the output register and the read pipeline are both free.
    // A read gets the SRAM port ahead of a write.
    assign w_rd_go    = (w_sc != '0) && !rd_pend_q && !out_valid_q;
    assign in_ready_o = !resetn && !w_full && !w_rd_go;
    assign w_push     = in_valid_i && in_ready_o;

    assign mem_we_o   = w_push;
    assign mem_add_o  = w_rd_go ? w_rd_ptr : w_wr_ptr;
    assign mem_wd_o   = in_data_i;

    // Output register. A word lands one cycle after its read was issued.
    // It cannot collide with a pop, because a read is never issued while
    // out_valid is set.
    always_comb begin
        rd_pend_d   = w_rd_go;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (rd_pend_q) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_rd_i;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge driver_clk or posedge resetn) begin
        if (resetn) begin
            rd_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            rd_pend_q   <= rd_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign count_o     = w_sc + {{ADDR_W{1'b0}}, rd_pend_q}
                              + {{ADDR_W{1'b0}}, out_valid_q};
    assign full_o      = w_full;
    assign empty_o     = (count_o == '0);

`ifdef SRAM_FIFO_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid_i && !in_ready_o && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge driver_clk or posedge resetn) begin
        if (resetn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule : sram_fifo_ctrl
`default_nettype wire
